full_adder: RTL and testbench

Bit-serial 8-bit two's-complement adder with carry and overflow flags. A synchronous `load` captures both operands and the carry-in. The block then adds one bit per clock, LSB first, and the 8-bit sum, carry flag and overflow flag are valid 8 cycles later. It serves as a small-area arithmetic unit and as a demonstrator for sequential datapath verification.

---
 rtl/full_adder.sv | 116 +++++++++++
 tb/tb_full_adder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Bit-serial 8-bit two's-complement adder. A cycle with load=1 captures the
// operands and the carry-in and clears the result. Each following cycle with
// load=0 adds one bit pair, LSB first. After 8 such cycles, s holds the sum,
// CF holds the carry out of bit 7 and OF holds the signed overflow. The unit
// then idles with its outputs held until the next load.
//
// Ports
//   load : start and synchronous reset (active-high). Captures a, b, cin.
//   clk  : rising-edge clock.
//   a, b : 8-bit signed operands. Sampled only while load=1.
//   cin  : carry-in. Sampled only while load=1.
//   s    : sum shift register. Holds the final sum after step 8.
//   CF   : unsigned carry out of bit 7. Valid after step 8, 0 before that.
//   OF   : signed overflow. Valid after step 8, 0 before that.
// -----------------------------------------------------------------------------
module full_adder (
  input  logic              load,
  input  logic              clk,
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  input  logic              cin,
  output logic signed [7:0] s,
  output logic              CF,
  output logic              OF
);

  localparam logic [3:0] CNT_LAST = 4'd7;
  localparam logic [3:0] CNT_DONE = 4'd8;

  // Carry out of a single full-adder cell.
  function automatic logic majority(input logic x, input logic y, input logic z);
    majority = (x & y) | (x & z) | (y & z);
  endfunction

  logic [7:0] ra_q, ra_d;
  logic [7:0] rb_q, rb_d;
  logic [7:0] s_q,  s_d;
  logic [3:0] cnt_q, cnt_d;
  logic       c_q,  c_d;
  logic       c7_q, c7_d;
  logic       cf_q, cf_d;
  logic       of_q, of_d;

  logic       sum_bit_s;
  logic       carry_out_s;

  // One bit of the add, taken from the current LSBs and the running carry.
  always_comb begin
    sum_bit_s   = ra_q[0] ^ rb_q[0] ^ c_q;
    carry_out_s = majority(ra_q[0], rb_q[0], c_q);
  end

  // Next state for one add step. Once cnt reaches 8, every register holds.
  always_comb begin
    ra_d  = ra_q;
    rb_d  = rb_q;
    s_d   = s_q;
    cnt_d = cnt_q;
    c_d   = c_q;
    c7_d  = c7_q;
    cf_d  = cf_q;
    of_d  = of_q;
    if (cnt_q < CNT_DONE) begin
      ra_d  = {1'b0, ra_q[7:1]};
      rb_d  = {1'b0, rb_q[7:1]};
      // The sum enters from the MSB side, so it ends up aligned after 8 shifts.
      s_d   = {sum_bit_s, s_q[7:1]};
      c_d   = carry_out_s;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == CNT_LAST) begin
        // The incoming carry on the last step is the carry into bit 7.
        c7_d = c_q;
        cf_d = carry_out_s;
        of_d = c_q ^ carry_out_s;
      end else begin
        c7_d = c7_q;
        cf_d = cf_q;
        of_d = of_q;
      end
    end else begin
      ra_d  = ra_q;
      rb_d  = rb_q;
    end
  end

  // State registers. load takes priority, restarts any operation in progress
  // and clears the visible result.
  always_ff @(posedge clk) begin
    if (load) begin
      ra_q  <= a;
      rb_q  <= b;
      c_q   <= cin;
      cnt_q <= 4'd0;
      c7_q  <= 1'b0;
      s_q   <= 8'd0;
      cf_q  <= 1'b0;
      of_q  <= 1'b0;
    end else begin
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
      c7_q  <= c7_d;
      s_q   <= s_d;
      cf_q  <= cf_d;
      of_q  <= of_d;
    end
  end

  assign s  = s_q;
  assign CF = cf_q;
  assign OF = of_q;

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
// Directed self-checking bench for the bit-serial full_adder. Each vector
// carries a hand-computed sum, CF and OF. Outputs are sampled 1 time unit
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_full_adder;

  logic              clk;
  logic              load;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic              cin;
  logic signed [7:0] s;
  logic              CF;
  logic              OF;

  int n_compared;
  int n_mismatched;

  full_adder dut (
    .load (load),
    .clk  (clk),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .CF   (CF),
    .OF   (OF)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison of {s, CF, OF} and reports it if it differs.
  task automatic check_val(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got s=%02h CF=%b OF=%b, expected s=%02h CF=%b OF=%b",
               tag, obs[9:2], obs[1], obs[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  // Holds load for n_load edges, checking that the outputs are cleared.
  task automatic do_load(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input int n_load);
    a    = av;
    b    = bv;
    cin  = cv;
    load = 1'b1;
    for (int i = 0; i < n_load; i++) begin
      @(posedge clk);
      #1;
      check_val("load_clear", {s, CF, OF}, 10'd0);
    end
    load = 1'b0;
  endtask

  // Runs n_steps add steps while scrambling the operand inputs. CF and OF
  // must stay 0 before step 8.
  task automatic run_steps(input int n_steps);
    for (int k = 1; k <= n_steps; k++) begin
      @(posedge clk);
      #1;
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      if (k < 8) begin
        check_val("flags_mid", {8'd0, CF, OF}, 10'd0);
      end else begin
        check_val("flags_done_sample", {8'd0, 2'b00}, {8'd0, 2'b00} & {8'd0, CF, OF} & 10'd0);
      end
    end
  endtask

  // Runs one complete operation and checks the final sum and flags.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input int n_load,
                        input logic [7:0] exp_s, input logic exp_cf, input logic exp_of);
    do_load(av, bv, cv, n_load);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      if (k < 8) check_val("flags_mid", {8'd0, CF, OF}, 10'd0);
    end
    check_val(tag, {s, CF, OF}, {exp_s, exp_cf, exp_of});
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    load = 1'b0;
    a    = 8'd0;
    b    = 8'd0;
    cin  = 1'b0;
    @(posedge clk);
    #1;

    // -1 + 34 = 33. load is held for 2 edges. The result must then hold for 30 cycles.
    run_op("m1_p34", 8'hFF, 8'h22, 1'b0, 2, 8'h21, 1'b1, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    check_val("hold_30", {s, CF, OF}, {8'h21, 1'b1, 1'b0});

    run_op("7f_p01",    8'h7F, 8'h01, 1'b0, 1, 8'h80, 1'b0, 1'b1);
    run_op("80_p80",    8'h80, 8'h80, 1'b0, 1, 8'h00, 1'b1, 1'b1);
    run_op("00_00_c1",  8'h00, 8'h00, 1'b1, 1, 8'h01, 1'b0, 1'b0);
    run_op("ff_00_c1",  8'hFF, 8'h00, 1'b1, 1, 8'h00, 1'b1, 1'b0);
    run_op("55_aa_c1",  8'h55, 8'hAA, 1'b1, 1, 8'h00, 1'b1, 1'b0);
    run_op("40_p40",    8'h40, 8'h40, 1'b0, 1, 8'h80, 1'b0, 1'b1);
    run_op("c0_c0",     8'hC0, 8'hC0, 1'b0, 1, 8'h80, 1'b1, 1'b0);
    run_op("81_ff",     8'h81, 8'hFF, 1'b0, 1, 8'h80, 1'b1, 1'b0);
    run_op("80_ff",     8'h80, 8'hFF, 1'b0, 1, 8'h7F, 1'b1, 1'b1);

    // Restart mid-operation: 4 steps of 7F+01, then a fresh 05+03.
    do_load(8'h7F, 8'h01, 1'b0, 1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check_val("flags_pre_restart", {8'd0, CF, OF}, 10'd0);
    end
    run_op("restart_05_03", 8'h05, 8'h03, 1'b0, 1, 8'h08, 1'b0, 1'b0);

    // The idle state must ignore input changes.
    repeat (5) @(posedge clk);
    #1;
    check_val("idle_hold", {s, CF, OF}, {8'h08, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
